// File: rtl/bool_2a.sv
// Registered three-input Boolean function: e is the TRUTH_TABLE entry indexed by {a,b,c},
// captured on every rising clk edge and cleared asynchronously by rst_n.
module bool_2a #(
  parameter logic [7:0] TRUTH_TABLE = 8'hCA
) (
  input  logic clk,
  input  logic rst_n,
  input  logic a,
  input  logic b,
  input  logic c,
  output logic e
);

  logic [2:0] idx;
  logic       e_d;
  logic       e_q;

  // An X/Z on any input makes the index unknown, so e_d (and e) go X rather than masking it.
  always_comb begin
    idx = {a, b, c};
    e_d = TRUTH_TABLE[idx];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e_q <= 1'b0;
    end else begin
      e_q <= e_d;
    end
  end

  assign e = e_q;

endmodule

// File: tb/tb_bool_2a.sv
// Scoreboard bench for bool_2a: default 2:1-select table and an XOR3 override driven in parallel.
module tb_bool_2a;

  logic clk;
  logic rst_n;
  logic a;
  logic b;
  logic c;
  logic e_def;
  logic e_xor;

  typedef struct packed {
    logic def;
    logic xr;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;
  logic [7:0] seen = 8'h00;

  bool_2a dut_def (
    .clk   (clk),
    .rst_n (rst_n),
    .a     (a),
    .b     (b),
    .c     (c),
    .e     (e_def)
  );

  bool_2a #(
    .TRUTH_TABLE (8'h96)
  ) dut_xor (
    .clk   (clk),
    .rst_n (rst_n),
    .a     (a),
    .b     (b),
    .c     (c),
    .e     (e_xor)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic act, input logic req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, req, $time);
    end
  endtask

  // Reference model: the mux and parity rules themselves, forced low by reset.
  function automatic exp_t model(input logic ra, input logic rb, input logic rc, input logic rst);
    exp_t r;
    if (!rst) begin
      r.def = 1'b0;
      r.xr  = 1'b0;
    end else begin
      r.def = ra ? rb : rc;
      r.xr  = (ra + rb + rc) % 2 == 1;
    end
    return r;
  endfunction

  // Drive one cycle's inputs at the falling edge and queue what the next rising edge must give.
  task automatic drive(input logic na, input logic nb, input logic nc, input logic nrst);
    @(negedge clk);
    a     = na;
    b     = nb;
    c     = nc;
    rst_n = nrst;
    sb.push_back(model(na, nb, nc, nrst));
    if (nrst) seen[{na, nb, nc}] = 1'b1;
  endtask

  // Monitor: the registered output is presented after every rising edge.
  initial begin
    exp_t ex;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        ex = sb.pop_front();
        check("e_default", e_def, ex.def);
        check("e_xor3", e_xor, ex.xr);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    a     = 1'b1;
    b     = 1'b1;
    c     = 1'b1;
    rst_n = 1'b0;
    #1;
    check("reset_async_def", e_def, 1'b0);
    check("reset_async_xor", e_xor, 1'b0);

    // Reset held with all inputs high, then released: first edge loads index 111.
    repeat (3) drive(1'b1, 1'b1, 1'b1, 1'b0);
    drive(1'b1, 1'b1, 1'b1, 1'b1);

    // Sweep: a toggles every 5 cycles, b every 10, c every 15.
    for (int i = 0; i < 100; i++) begin
      drive(1'((i / 5) % 2), 1'((i / 10) % 2), 1'((i / 15) % 2), 1'b1);
    end

    // Back-to-back latency: 001 then 100.
    drive(1'b0, 1'b0, 1'b1, 1'b1);
    drive(1'b1, 1'b0, 1'b0, 1'b1);

    // Mid-run reset between edges with e=1.
    drive(1'b1, 1'b1, 1'b0, 1'b1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrun_reset_def", e_def, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 1'b1);

    // Glitch on c between edges while a=0 must not reach e.
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    #1;
    c = 1'b1;
    #2;
    c = 1'b0;
    check("glitch_hold_def", e_def, 1'b0);

    // Randomized traffic with occasional reset cycles.
    for (int i = 0; i < 300; i++) begin
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 19) != 0));
    end
    drive(1'b0, 1'b0, 1'b0, 1'b1);

    repeat (2) @(posedge clk);
    #2;
    check("scoreboard_drained", sb.size() == 0, 1'b1);
    check("all_combos_seen", &seen, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
